// File: rtl/range_frame_sequencer.sv
// rtl/range_frame_sequencer.sv - FIFO-buffered framed burst feeder for the range finder (optional RFS_AUTO_RESTART_EN)
module range_frame_sequencer #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_in_data,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic             i_start,
    input  logic [AW:0]      i_frame_len,
    output logic [WIDTH-1:0] o_data_out,
    output logic             o_go,
    output logic             o_finish,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_cfg_err,
    output logic [AW:0]      o_fill_level
);

    localparam int          DEPTH   = 2 ** AW;
    localparam logic [AW:0] C_DEPTH = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] C_TWO   = (AW + 1)'(2);
    localparam logic [AW:0] C_ONE   = (AW + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [AW:0]      w_count_next;
    logic [AW:0]      r_len_q;
    logic [AW:0]      r_cnt;

    logic [WIDTH-1:0] r_data_out;
    logic             r_go;
    logic             r_finish;
    logic             r_cfg_err;

    logic             w_in_ready;
    logic             w_push;
    logic             w_pop;
    logic             w_last;
    logic             w_len_ok;
    logic             w_load;

`ifdef RFS_AUTO_RESTART_EN
    logic             r_stop;
`endif

    assign w_in_ready = (r_count < C_DEPTH);
    assign w_push     = i_in_valid && w_in_ready;
    // A frame is only entered once fully buffered, so every EMIT cycle has data.
    assign w_pop      = (r_state == S_EMIT);
    assign w_last     = (r_cnt == C_ONE);
    assign w_len_ok   = (i_frame_len >= C_TWO) && (i_frame_len <= C_DEPTH);
    // Counter reloads on entering EMIT, including a back-to-back restart.
    assign w_load     = (w_next == S_EMIT) && ((r_state != S_EMIT) || w_last);

    // Occupancy after this cycle's push/pop, used by count and restart decision
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + C_ONE;
            2'b01:   w_count_next = r_count - C_ONE;
            default: w_count_next = r_count;
        endcase
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (i_start && w_len_ok) w_next = S_FILL;
            S_FILL: if (r_count >= r_len_q) w_next = S_EMIT;
            S_EMIT: begin
                if (w_last) begin
`ifdef RFS_AUTO_RESTART_EN
                    if (r_stop || i_start)
                        w_next = S_IDLE;
                    else if (w_count_next >= r_len_q)
                        w_next = S_EMIT;
                    else
                        w_next = S_FILL;
`else
                    w_next = S_IDLE;
`endif
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clock) begin
        if (i_reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // FIFO storage; contents need no reset since pointers and count are flushed
    always_ff @(posedge i_clock) begin
        if (w_push)
            r_mem[r_wr_ptr] <= i_in_data;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_next;
        end
    end

    // Frame length latch and EMIT down-counter
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_len_q <= '0;
            r_cnt   <= '0;
        end else begin
            if (r_state == S_IDLE && i_start)
                r_len_q <= i_frame_len;
            if (w_load)
                r_cnt <= r_len_q;
            else if (w_pop)
                r_cnt <= r_cnt - C_ONE;
        end
    end

`ifdef RFS_AUTO_RESTART_EN
    // Stop request: start while busy lets the current frame finish, then idles
    always_ff @(posedge i_clock) begin
        if (i_reset || r_state == S_IDLE)
            r_stop <= 1'b0;
        else if (i_start)
            r_stop <= 1'b1;
    end
`endif

    // Registered burst outputs, one cycle behind the pop
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_data_out <= '0;
            r_go       <= 1'b0;
            r_finish   <= 1'b0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_go      <= w_pop && (r_cnt == r_len_q);
            r_finish  <= w_pop && w_last;
            r_cfg_err <= (r_state == S_IDLE) && i_start && !w_len_ok;
            if (w_pop)
                r_data_out <= r_mem[r_rd_ptr];
        end
    end

    assign o_in_ready   = w_in_ready;
    assign o_data_out   = r_data_out;
    assign o_go         = r_go;
    assign o_finish     = r_finish;
    assign o_done       = r_finish;
    assign o_cfg_err    = r_cfg_err;
    assign o_busy       = (r_state != S_IDLE);
    assign o_fill_level = r_count;

endmodule

// File: tb/tb_range_frame_sequencer.sv
// tb/tb_range_frame_sequencer.sv - directed self-checking bench for range_frame_sequencer
module tb_range_frame_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       start;
    logic [4:0] frame_len;
    logic [7:0] data_out;
    logic       go;
    logic       finish;
    logic       busy;
    logic       done;
    logic       cfg_err;
    logic [4:0] fill_level;

    int n_checks = 0;
    int n_fail   = 0;

    range_frame_sequencer #(.WIDTH(8), .AW(4)) dut (
        .i_clock      (clock),
        .i_reset      (reset),
        .i_in_data    (in_data),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .i_start      (start),
        .i_frame_len  (frame_len),
        .o_data_out   (data_out),
        .o_go         (go),
        .o_finish     (finish),
        .o_busy       (busy),
        .o_done       (done),
        .o_cfg_err    (cfg_err),
        .o_fill_level (fill_level)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_seq(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = base + 8'(i);
            tick;
        end
        in_valid = 1'b0;
    endtask

    task automatic do_start(input logic [4:0] len);
        frame_len = len;
        start     = 1'b1;
        tick;
        start     = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; start = 1'b0; frame_len = '0;
        tick; tick;
        reset = 1'b0;
        chk("rst_fill", fill_level, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_data", data_out, 0);
        chk("rst_go", go, 0);
        chk("rst_cfg", cfg_err, 0);

        // 1: basic 4-sample frame
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 8'((i + 1) * 10); tick;
        end
        in_valid = 1'b0;
        chk("t1_fill", fill_level, 4);
        do_start(5'd4);
        chk("t1_busy", busy, 1);
        tick; tick;
        chk("t1_go", go, 1);       chk("t1_d0", data_out, 10); chk("t1_fin0", finish, 0);
        tick;
        chk("t1_go1", go, 0);      chk("t1_d1", data_out, 20);
        tick;
        chk("t1_d2", data_out, 30); chk("t1_fin2", finish, 0);
        tick;
        chk("t1_d3", data_out, 40); chk("t1_fin", finish, 1); chk("t1_done", done, 1);
        chk("t1_go3", go, 0);       chk("t1_busy_end", busy, 0); chk("t1_fill_end", fill_level, 0);

        // 2: illegal frame lengths
        do_start(5'd1);
        chk("t2_cfg1", cfg_err, 1); chk("t2_busy1", busy, 0);
        tick;
        chk("t2_cfg1_off", cfg_err, 0); chk("t2_go1", go, 0);
        do_start(5'd17);
        chk("t2_cfg17", cfg_err, 1); chk("t2_busy17", busy, 0);
        tick;
        chk("t2_cfg17_off", cfg_err, 0); chk("t2_go17", go, 0); chk("t2_busy_end", busy, 0);

        // 3: slow trickle, no go before the frame is buffered
        do_start(5'd3);
        for (int w = 0; w < 3; w++) begin
            in_valid = 1'b1; in_data = 8'h31 + 8'(w); tick; in_valid = 1'b0;
            if (w < 2) begin
                tick; tick;
                chk("t3_nogo", go, 0); chk("t3_busy", busy, 1);
            end
        end
        chk("t3_nogo_w3", go, 0);
        tick;
        chk("t3_nogo_emit", go, 0);
        tick;
        chk("t3_go", go, 1); chk("t3_d0", data_out, 8'h31);
        tick;
        chk("t3_d1", data_out, 8'h32);
        tick;
        chk("t3_d2", data_out, 8'h33); chk("t3_fin", finish, 1);

        // 4: full FIFO, dropped write, push during EMIT
        write_seq(8'h40, 16);
        chk("t4_ready_full", in_ready, 0); chk("t4_fill16", fill_level, 16);
        in_valid = 1'b1; in_data = 8'hEE; tick; in_valid = 1'b0;
        chk("t4_fill_drop", fill_level, 16);
        reset = 1'b1; tick; reset = 1'b0;
        chk("t4_flush", fill_level, 0); chk("t4_ready", in_ready, 1);
        write_seq(8'hA0, 8);
        do_start(5'd4);
        tick;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_data = 8'hB0 + 8'(k);
            tick;
            chk("t4_pp_data", data_out, 8'hA0 + 8'(k));
            chk("t4_pp_fill", fill_level, 8);
            chk("t4_pp_go", go, (k == 0) ? 1 : 0);
            chk("t4_pp_fin", finish, (k == 3) ? 1 : 0);
        end
        in_valid = 1'b0;
        do_start(5'd8);
        tick;
        for (int k = 0; k < 8; k++) begin
            tick;
            chk("t4_order", data_out, (k < 4) ? 8'hA4 + 8'(k) : 8'hB0 + 8'(k - 4));
        end
        chk("t4_fill_end", fill_level, 0); chk("t4_busy_end", busy, 0);

        // 5: reset during the second EMIT cycle
        write_seq(8'hC0, 8);
        do_start(5'd8);
        tick; tick;
        chk("t5_go", go, 1); chk("t5_d0", data_out, 8'hC0);
        reset = 1'b1; tick; reset = 1'b0;
        chk("t5_go0", go, 0); chk("t5_fin0", finish, 0); chk("t5_done0", done, 0);
        chk("t5_data0", data_out, 0); chk("t5_fill0", fill_level, 0); chk("t5_busy0", busy, 0);
        tick;
        chk("t5_fin_after", finish, 0);

`ifdef RFS_AUTO_RESTART_EN
        // 6: back-to-back frames, then stop request
        write_seq(8'hD0, 8);
        do_start(5'd2);
        tick;
        for (int k = 0; k < 8; k++) begin
            tick;
            chk("t6_data", data_out, 8'hD0 + 8'(k));
            chk("t6_go", go, (k % 2 == 0) ? 1 : 0);
            chk("t6_fin", finish, (k % 2 == 1) ? 1 : 0);
            chk("t6_busy", busy, 1);
        end
        chk("t6_fill0", fill_level, 0);
        start = 1'b1; tick; start = 1'b0;
        write_seq(8'hE0, 2);
        tick; tick;
        chk("t6_go_last", go, 1); chk("t6_d_last0", data_out, 8'hE0);
        tick;
        chk("t6_fin_last", finish, 1); chk("t6_d_last1", data_out, 8'hE1); chk("t6_idle", busy, 0);
        tick;
        chk("t6_nogo", go, 0); chk("t6_idle2", busy, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
